// File: rtl/mmio_uart_tx_pkg.sv
// mmio_uart_tx_pkg
//   Shared definitions for the memory-mapped UART transmitter:
//   register offsets, STATUS bit positions and serializer state codes.
package mmio_uart_tx_pkg;

    // Register offsets within the 4-word block
    localparam logic [1:0] UART_OFF_TXDATA  = 2'd0;
    localparam logic [1:0] UART_OFF_STATUS  = 2'd1;
    localparam logic [1:0] UART_OFF_DIVISOR = 2'd2;

    // STATUS bit positions
    localparam int UART_STAT_EMPTY   = 0;
    localparam int UART_STAT_FULL    = 1;
    localparam int UART_STAT_BUSY    = 2;
    localparam int UART_STAT_OVF     = 3;
    localparam int UART_STAT_CNT_LSB = 4;   // count occupies [9:4]

    // Serializer states
    typedef enum logic [1:0] {
        UART_ST_IDLE  = 2'd0,
        UART_ST_START = 2'd1,
        UART_ST_DATA  = 2'd2,
        UART_ST_STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if
//   Core data-memory port as seen by the UART block.
//   i_addr    30  word address
//   i_data    32  store data
//   i_we       1  store strobe, one cycle per store
//   i_mask     4  byte-lane write mask
//   o_rd_data 32  combinational read data (0 when not selected)
interface mmio_uart_tx_if;
    logic [29:0] i_addr;
    logic [31:0] i_data;
    logic        i_we;
    logic [3:0]  i_mask;
    logic [31:0] o_rd_data;

    modport master (output i_addr, output i_data, output i_we, output i_mask,
                    input  o_rd_data);
    modport slave  (input  i_addr, input  i_data, input  i_we, input  i_mask,
                    output o_rd_data);
endinterface

// File: rtl/mmio_uart_tx_fifo.sv
// mmio_uart_tx_fifo
//   Synchronous byte FIFO feeding the serializer. Read data is the head
//   entry, valid whenever o_empty is low.
//   clk, rst   clock, synchronous active-high reset
//   i_push     write i_data (ignored when full unless popping the same cycle)
//   i_pop      consume head entry (ignored when empty)
//   o_data     head entry
//   o_full, o_empty, o_count   occupancy
module mmio_uart_tx_fifo #(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [7:0]    i_data,
    input  logic          i_pop,
    output logic [7:0]    o_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];

    // A pop frees a slot in the same cycle, so a push while full is taken
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx
//   Memory-mapped 8N1 UART transmitter. Stores to TXDATA fill a byte FIFO
//   which the serializer drains onto o_tx, LSB first, DIVISOR clocks per bit.
//   Reads are combinational so a single-cycle core gets data in-cycle.
//   Optional feature macro: MMIO_UART_IRQ_EN (TX-empty interrupt, IE bit
//   in DIVISOR[16]); without it DIVISOR[16] reads 0 and o_irq is tied low.
//   Ports:
//     clk, rst   clock, synchronous active-high reset
//     bus        core data-memory port (slave side)
//     o_tx       serial line, idles high
//     o_irq      TX-empty interrupt
//   Map (word offsets): 0 TXDATA (W), 1 STATUS, 2 DIVISOR, 3 reserved.
//   STATUS: [0] empty [1] full [2] busy [3] ovf (W1C via bit 3) [9:4] count
module mmio_uart_tx import mmio_uart_tx_pkg::*; #(
    parameter logic [29:0] BASE_ADDR  = 30'h0400_0000,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] CLK_DIV    = 16'd434
) (
    input  logic                 clk,
    input  logic                 rst,
    mmio_uart_tx_if.slave        bus,
    output logic                 o_tx,
    output logic                 o_irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          w_sel;
    logic [1:0]    w_off;
    logic          w_push_req;
    logic          w_wr_status;
    logic          w_wr_div;
    logic [15:0]   w_div_next;
    logic          w_pop;
    logic [7:0]    w_fifo_data;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [5:0]    w_count6;
    logic          w_busy;
    logic          w_ie;
    logic [31:0]   w_status;
    logic          w_unused;

    logic [15:0]   r_div;
    logic          r_ovf;
    uart_state_t   r_state;
    logic          r_tx;
    logic [15:0]   r_baud;
    logic [15:0]   r_div_lat;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;

    assign w_sel       = (bus.i_addr[29:2] == BASE_ADDR[29:2]);
    assign w_off       = bus.i_addr[1:0];
    assign w_push_req  = bus.i_we & w_sel & (w_off == UART_OFF_TXDATA) & bus.i_mask[0];
    assign w_wr_status = bus.i_we & w_sel & (w_off == UART_OFF_STATUS);
    assign w_wr_div    = bus.i_we & w_sel & (w_off == UART_OFF_DIVISOR);
    assign w_div_next  = {bus.i_mask[1] ? bus.i_data[15:8] : r_div[15:8],
                          bus.i_mask[0] ? bus.i_data[7:0]  : r_div[7:0]};
    assign w_busy      = (r_state != UART_ST_IDLE);
    assign w_count6    = 6'(w_count);
    assign w_unused    = &{1'b0, bus.i_data[31:16], bus.i_mask[3:2]};

    // Pop exactly when the FSM leaves IDLE or chains a frame out of STOP
    assign w_pop = ~w_empty & ((r_state == UART_ST_IDLE) |
                               ((r_state == UART_ST_STOP) & (r_baud == 16'd0)));

    mmio_uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push_req),
        .i_data  (bus.i_data[7:0]),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= CLK_DIV;
            r_ovf <= 1'b0;
        end else begin
            // Only a push that is actually dropped raises ovf
            if (w_push_req & w_full & ~w_pop) begin
                r_ovf <= 1'b1;
            end else if (w_wr_status & bus.i_mask[0] & bus.i_data[3]) begin
                r_ovf <= 1'b0;
            end
            if (w_wr_div) begin
                r_div <= (w_div_next == 16'd0) ? 16'd1 : w_div_next;
            end
        end
    end

`ifdef MMIO_UART_IRQ_EN
    logic r_ie;
    logic r_irq;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ie  <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            if (w_wr_div & bus.i_mask[2]) r_ie <= bus.i_data[16];
            r_irq <= r_ie & w_empty & ~w_busy;
        end
    end

    assign w_ie  = r_ie;
    assign o_irq = r_irq;
`else
    assign w_ie  = 1'b0;
    assign o_irq = 1'b0;
`endif

    // Serializer. The baud counter runs DIVISOR-1 .. 0 in every state, so
    // each of start, 8 data and stop lasts exactly DIVISOR cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= UART_ST_IDLE;
            r_tx      <= 1'b1;
            r_baud    <= 16'd0;
            r_div_lat <= CLK_DIV;
            r_bit     <= 3'd0;
            r_shift   <= 8'd0;
        end else begin
            case (r_state)
                UART_ST_IDLE: begin
                    if (!w_empty) begin
                        r_state   <= UART_ST_START;
                        r_tx      <= 1'b0;
                        r_shift   <= w_fifo_data;
                        r_div_lat <= r_div;
                        r_baud    <= r_div - 16'd1;
                    end
                end
                UART_ST_START: begin
                    if (r_baud == 16'd0) begin
                        r_state <= UART_ST_DATA;
                        r_tx    <= r_shift[0];
                        r_bit   <= 3'd0;
                        r_baud  <= r_div_lat - 16'd1;
                    end else begin
                        r_baud  <= r_baud - 16'd1;
                    end
                end
                UART_ST_DATA: begin
                    if (r_baud == 16'd0) begin
                        r_baud <= r_div_lat - 16'd1;
                        if (r_bit == 3'd7) begin
                            r_state <= UART_ST_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_tx    <= r_shift[1];
                            r_bit   <= r_bit + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud - 16'd1;
                    end
                end
                UART_ST_STOP: begin
                    if (r_baud == 16'd0) begin
                        if (!w_empty) begin
                            r_state   <= UART_ST_START;
                            r_tx      <= 1'b0;
                            r_shift   <= w_fifo_data;
                            r_div_lat <= r_div;
                            r_baud    <= r_div - 16'd1;
                        end else begin
                            r_state   <= UART_ST_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud - 16'd1;
                    end
                end
                default: begin
                    r_state <= UART_ST_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign o_tx = r_tx;

    always_comb begin
        w_status = 32'd0;
        w_status[UART_STAT_EMPTY] = w_empty;
        w_status[UART_STAT_FULL]  = w_full;
        w_status[UART_STAT_BUSY]  = w_busy;
        w_status[UART_STAT_OVF]   = r_ovf;
        w_status[UART_STAT_CNT_LSB +: 6] = w_count6;
    end

    always_comb begin
        bus.o_rd_data = 32'd0;
        if (w_sel) begin
            case (w_off)
                UART_OFF_STATUS:  bus.o_rd_data = w_status;
                UART_OFF_DIVISOR: bus.o_rd_data = {15'd0, w_ie, r_div};
                default:          bus.o_rd_data = 32'd0;
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx
//   Directed bench for mmio_uart_tx. Inputs change on the falling edge,
//   outputs are sampled on the falling edge (or 1 ns after it for reads).
module tb_mmio_uart_tx;
    localparam logic [29:0] BASE = 30'h0400_0000;
    localparam logic [1:0]  O_TX = 2'd0;
    localparam logic [1:0]  O_ST = 2'd1;
    localparam logic [1:0]  O_DV = 2'd2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic o_tx;
    logic o_irq;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    logic [7:0]  exp_q [$];
    logic [31:0] wr_q  [$];
    logic [31:0] rd;

    mmio_uart_tx_if bus_if ();

    mmio_uart_tx #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (8),
        .CLK_DIV    (16'd434)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus_if.slave),
        .o_tx  (o_tx),
        .o_irq (o_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic read_reg(input logic [1:0] off, output logic [31:0] d);
        bus_if.i_we   = 1'b0;
        bus_if.i_addr = BASE + 30'(off);
        #1;
        d = bus_if.o_rd_data;
    endtask

    task automatic check_reg(input string tag, input logic [1:0] off, input logic [31:0] exp);
        logic [31:0] d;
        read_reg(off, d);
        check(tag, d, exp);
    endtask

    // Writes every word of wr_q on consecutive cycles; returns on the
    // falling edge after the last store has been clocked in.
    task automatic store_seq(input logic [1:0] off, input logic [3:0] mask);
        foreach (wr_q[k]) begin
            @(negedge clk);
            bus_if.i_addr = BASE + 30'(off);
            bus_if.i_data = wr_q[k];
            bus_if.i_mask = mask;
            bus_if.i_we   = 1'b1;
        end
        @(negedge clk);
        bus_if.i_we = 1'b0;
    endtask

    task automatic store(input logic [1:0] off, input logic [31:0] data, input logic [3:0] mask);
        wr_q = '{data};
        store_seq(off, mask);
    endtask

    // Checks o_tx cycle by cycle for the frames in exp_q; the current
    // sample point is the first cycle of the first start bit.
    task automatic expect_line(input int div);
        int total;
        int f;
        int b;
        logic e;
        total = exp_q.size() * 10 * div;
        for (int i = 0; i < total; i++) begin
            if (i > 0) @(negedge clk);
            f = i / (10 * div);
            b = (i % (10 * div)) / div;
            if (b == 0)      e = 1'b0;
            else if (b == 9) e = 1'b1;
            else             e = exp_q[f][b-1];
            check($sformatf("line frame%0d bit%0d cyc%0d", f, b, i), {31'd0, o_tx}, {31'd0, e});
        end
    endtask

    initial begin
        bus_if.i_addr = '0;
        bus_if.i_data = '0;
        bus_if.i_mask = '0;
        bus_if.i_we   = 1'b0;

        // 1. reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_tx", {31'd0, o_tx}, 32'd1);
        check("rst_irq", {31'd0, o_irq}, 32'd0);
        check_reg("rst_status", O_ST, 32'h001);
        check_reg("rst_divisor", O_DV, 32'h0000_01B2);
        check_reg("txdata_reads0", O_TX, 32'h0);

        // 2. single frame, DIVISOR=4, 0x55
        store(O_DV, 32'd4, 4'b0011);
        check_reg("div4", O_DV, 32'd4);
        store(O_TX, 32'h55, 4'b0001);
        check("latency_still_high", {31'd0, o_tx}, 32'd1);
        @(negedge clk);
        exp_q = '{8'h55};
        expect_line(4);
        check_reg("busy_in_stop", O_ST, 32'h005);
        @(negedge clk);
        check_reg("busy_cleared", O_ST, 32'h001);

        // 3. overflow, DIVISOR=1
        store(O_DV, 32'd1, 4'b0011);
        store(O_TX, 32'hA5, 4'b0001);
        wr_q = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h14, 32'h15, 32'h16, 32'h17, 32'h18};
        store_seq(O_TX, 4'b0001);
        check_reg("full_ovf", O_ST, 32'h08E);
        @(negedge clk);
        exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
        expect_line(1);
        @(negedge clk);
        check_reg("drained_ovf_sticky", O_ST, 32'h009);
        check("no_ninth_byte", {31'd0, o_tx}, 32'd1);
        store(O_ST, 32'h8, 4'b0001);
        check_reg("ovf_cleared", O_ST, 32'h001);

        // 4. masks and divisor corner cases
        store(O_TX, 32'h77, 4'b1110);
        check_reg("masked_no_push", O_ST, 32'h001);
        repeat (2) @(negedge clk);
        check("masked_line_idle", {31'd0, o_tx}, 32'd1);
        store(O_DV, 32'd0, 4'b0011);
        check_reg("div0_as1", O_DV, 32'd1);
        store(O_DV, 32'h0000_0300, 4'b0010);
        check_reg("div_lane1", O_DV, 32'h0000_0301);
        store(O_DV, 32'h0000_ABCD, 4'b0001);
        check_reg("div_lane0", O_DV, 32'h0000_03CD);
        store(2'd3, 32'hFFFF_FFFF, 4'b1111);
        check_reg("off3_reads0", 2'd3, 32'h0);
        check_reg("off3_no_effect_div", O_DV, 32'h0000_03CD);
        check_reg("off3_no_effect_st", O_ST, 32'h001);
        bus_if.i_addr = BASE + 30'h5;
        #1;
        check("unselected_reads0", bus_if.o_rd_data, 32'h0);

        // 5. back-to-back frames, DIVISOR=2
        store(O_DV, 32'd2, 4'b0011);
        wr_q = '{32'h3C, 32'hC3};
        store_seq(O_TX, 4'b0001);
        exp_q = '{8'h3C, 8'hC3};
        expect_line(2);
        @(negedge clk);
        check_reg("b2b_done_40", O_ST, 32'h001);

        // 6. interrupt
`ifdef MMIO_UART_IRQ_EN
        store(O_DV, 32'h0001_0002, 4'b0111);
        check_reg("ie_set", O_DV, 32'h0001_0002);
        @(negedge clk);
        check("irq_idle_empty", {31'd0, o_irq}, 32'd1);
        store(O_TX, 32'h81, 4'b0001);
        @(negedge clk);
        check("irq_low_busy", {31'd0, o_irq}, 32'd0);
        repeat (19) @(negedge clk);
        check_reg("irq_frame_busy", O_ST, 32'h005);
        @(negedge clk);
        check_reg("irq_busy_fell", O_ST, 32'h001);
        check("irq_not_yet", {31'd0, o_irq}, 32'd0);
        @(negedge clk);
        check("irq_one_after", {31'd0, o_irq}, 32'd1);
        store(O_TX, 32'h18, 4'b0001);
        @(negedge clk);
        check("irq_low_next", {31'd0, o_irq}, 32'd0);
        repeat (21) @(negedge clk);
        check("irq_high_again", {31'd0, o_irq}, 32'd1);
`else
        store(O_DV, 32'h0001_0002, 4'b0111);
        check_reg("ie_ignored", O_DV, 32'h0000_0002);
        store(O_TX, 32'h81, 4'b0001);
        repeat (23) @(negedge clk);
        check_reg("noirq_idle", O_ST, 32'h001);
        check("irq_tied0", {31'd0, o_irq}, 32'd0);
`endif

        // 7. reset mid-frame
        store(O_DV, 32'd4, 4'b0011);
        wr_q = '{32'hF0, 32'h0F, 32'hAA};
        store_seq(O_TX, 4'b0001);
        repeat (2) @(negedge clk);
        check("midframe_low", {31'd0, o_tx}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_tx_high", {31'd0, o_tx}, 32'd1);
        check_reg("rst_mid_fifo_flushed", O_ST, 32'h001);
        check_reg("rst_mid_div", O_DV, 32'h0000_01B2);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("after_rst_idle", {31'd0, o_tx}, 32'd1);
        check_reg("after_rst_status", O_ST, 32'h001);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
